// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// mc_cpu_pkg: opcode/funct constants, ALU-op and FSM state enums for mc_cpu.
// Revision 1.0
package mc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL,
        ALU_ILL
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// mc_regfile: NREG x XLEN register file, two async reads, one sync write; register 0 is hardwired zero.
// Revision 1.0
module mc_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs_addr,
    output logic [XLEN-1:0] rs_data,
    input  logic [AW-1:0]   rt_addr,
    output logic [XLEN-1:0] rt_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];

endmodule
`default_nettype wire

// File: rtl/mc_cpu.sv
`default_nettype none
// mc_cpu: 4-state-per-instruction multicycle CPU (add/sub/and/or/addi); MC_CPU_MUL_EN adds mul.
// Revision 1.0
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int PC_W     = 32,
    parameter int RESET_PC = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic [PC_W-1:0] pc_o,
    output logic            busy_o,
    output logic            retire_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o
);

    localparam int AW = $clog2(NREG);

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] op_a, op_b, result;
    alu_op_t         alu_op;
    logic [4:0]      dest;

    logic [XLEN-1:0] rs_val, rt_val, alu_out;
    alu_op_t         dec_op;
    logic [4:0]      dec_dest;
    logic [31:0]     imm_ext;

    mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .rs_addr (ir[21 +: AW]),
        .rs_data (rs_val),
        .rt_addr (ir[16 +: AW]),
        .rt_data (rt_val),
        .we      (wb_en_o),
        .waddr   (dest[AW-1:0]),
        .wdata   (result)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_i) state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack_i) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     state_next = start_i ? ST_FETCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign imm_ext = sext16(ir[15:0]);

    always_comb begin
        dec_op   = ALU_ILL;
        dec_dest = ir[15:11];
        if (ir[31:26] == OP_RTYPE) begin
            case (ir[5:0])
                FN_ADD:  dec_op = ALU_ADD;
                FN_SUB:  dec_op = ALU_SUB;
                FN_AND:  dec_op = ALU_AND;
                FN_OR:   dec_op = ALU_OR;
`ifdef MC_CPU_MUL_EN
                FN_MUL:  dec_op = ALU_MUL;
`endif
                default: dec_op = ALU_ILL;
            endcase
        end else if (ir[31:26] == OP_ADDI) begin
            dec_op   = ALU_ADD;
            dec_dest = ir[20:16];
        end
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
`ifdef MC_CPU_MUL_EN
            ALU_MUL: alu_out = op_a * op_b;
`endif
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc     <= PC_W'(RESET_PC);
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            alu_op <= ALU_ILL;
            dest   <= '0;
        end else begin
            case (state)
                ST_FETCH: if (imem_ack_i) ir <= imem_data_i;
                ST_DECODE: begin
                    op_a   <= rs_val;
                    op_b   <= (ir[31:26] == OP_ADDI) ? imm_ext[XLEN-1:0] : rt_val;
                    alu_op <= dec_op;
                    dest   <= dec_dest;
                end
                ST_EXEC:  result <= alu_out;
                ST_WB:    pc <= pc + PC_W'(4);
                default: ;
            endcase
        end
    end

    // Gating with rst_i keeps every strobe low while reset is held, even mid-WB.
    assign imem_req_o  = rst_i && (state == ST_FETCH);
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign busy_o      = rst_i && (state != ST_IDLE);
    assign retire_o    = rst_i && (state == ST_WB);
    assign illegal_o   = retire_o && (alu_op == ALU_ILL);
    assign wb_en_o     = retire_o && (alu_op != ALU_ILL) && (dest[AW-1:0] != '0);
    assign wb_addr_o   = dest;
    assign wb_data_o   = result;

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu.sv
`default_nettype none
// tb_mc_cpu: randomized scoreboard bench for mc_cpu (default build and a 16-bit / 4-bit-PC instance).
module tb_mc_cpu;

    typedef struct {
        int          inst;
        logic        ill;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [2];
    logic        ack [2];
    logic [31:0] idata [2];
    int          stall [2];
    logic [31:0] mem [2][64];

    logic        req0, busy0, ret0, wen0, ill0;
    logic [31:0] addr0, pc0, wd0;
    logic [4:0]  wa0;
    logic        req1, busy1, ret1, wen1, ill1;
    logic [3:0]  addr1, pc1;
    logic [15:0] wd1;
    logic [4:0]  wa1;

    logic        obs_req [2], obs_busy [2], obs_ret [2], obs_wen [2], obs_ill [2];
    logic [31:0] obs_addr [2], obs_pc [2], obs_wd [2];
    logic [4:0]  obs_wa [2];

    exp_t            sb [$];
    longint unsigned mregs [2][32];
    logic [31:0]     mpc [2];
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    mc_cpu dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[0]),
        .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(ack[0]), .imem_data_i(idata[0]),
        .pc_o(pc0), .busy_o(busy0), .retire_o(ret0),
        .wb_en_o(wen0), .wb_addr_o(wa0), .wb_data_o(wd0), .illegal_o(ill0)
    );

    mc_cpu #(.XLEN(16), .NREG(32), .PC_W(4), .RESET_PC(12)) dut16 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[1]),
        .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(ack[1]), .imem_data_i(idata[1]),
        .pc_o(pc1), .busy_o(busy1), .retire_o(ret1),
        .wb_en_o(wen1), .wb_addr_o(wa1), .wb_data_o(wd1), .illegal_o(ill1)
    );

    assign obs_req[0] = req0;   assign obs_req[1] = req1;
    assign obs_busy[0] = busy0; assign obs_busy[1] = busy1;
    assign obs_ret[0] = ret0;   assign obs_ret[1] = ret1;
    assign obs_wen[0] = wen0;   assign obs_wen[1] = wen1;
    assign obs_ill[0] = ill0;   assign obs_ill[1] = ill1;
    assign obs_addr[0] = addr0; assign obs_addr[1] = {28'b0, addr1};
    assign obs_pc[0] = pc0;     assign obs_pc[1] = {28'b0, pc1};
    assign obs_wd[0] = wd0;     assign obs_wd[1] = {16'b0, wd1};
    assign obs_wa[0] = wa0;     assign obs_wa[1] = wa1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_w(input logic [5:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b00000, f};
    endfunction

    function automatic logic [31:0] i_w(input logic [4:0] rt, input logic [4:0] rs,
                                        input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) mregs[i][r] = 0;
        mpc[0] = 32'd0;
        mpc[1] = 32'd12;
        sb.delete();
    endfunction

    // Architectural model: executes one fetched word and records what its WB must show.
    function automatic void issue(input int i, input logic [31:0] w);
        longint unsigned mask = (i == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
        longint unsigned a    = mregs[i][w[25:21]];
        longint unsigned b    = mregs[i][w[20:16]];
        longint unsigned sx   = {{48{w[15]}}, w[15:0]};
        longint unsigned res  = 0;
        bit              legal = 1'b1;
        logic [4:0]      dst  = w[15:11];
        exp_t            e;
        if (w[31:26] == 6'd0) begin
            case (w[5:0])
                6'd32:   res = a + b;
                6'd34:   res = a - b;
                6'd36:   res = a & b;
                6'd37:   res = a | b;
`ifdef MC_CPU_MUL_EN
                6'd24:   res = a * b;
`endif
                default: legal = 1'b0;
            endcase
        end else if (w[31:26] == 6'd8) begin
            res = a + sx;
            dst = w[20:16];
        end else begin
            legal = 1'b0;
        end
        res     = res & mask;
        e.inst  = i;
        e.ill   = !legal;
        e.wen   = legal && (dst != 5'd0);
        e.waddr = dst;
        e.wdata = res[31:0];
        e.pc    = mpc[i];
        if (e.wen) mregs[i][dst] = res;
        mpc[i] = (mpc[i] + 32'd4) & ((i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F);
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  rs  = 5'($urandom_range(0, 7));
        logic [4:0]  rt  = 5'($urandom_range(0, 7));
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 6))
            0: return r_w(6'b100000, rd, rs, rt);
            1: return r_w(6'b100010, rd, rs, rt);
            2: return r_w(6'b100100, rd, rs, rt);
            3: return r_w(6'b100101, rd, rs, rt);
            4: return r_w(6'b011000, rd, rs, rt);
            5: return i_w(rt, rs, imm);
            default: return ($urandom_range(0, 1) == 0) ? {6'b111111, 26'($urandom)}
                                                        : r_w(6'b000001, rd, rs, rt);
        endcase
    endfunction

    // Instruction memory responder; an acked fetch is the point where expectation is issued.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (obs_req[i] && stall[i] == 0) begin
                    ack[i]   = 1'b1;
                    idata[i] = mem[i][obs_addr[i][7:2]];
                    issue(i, idata[i]);
                end else begin
                    ack[i] = 1'b0;
                    if (obs_req[i] && stall[i] > 0) stall[i]--;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (obs_ret[i]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 64'(i), 64'hFF);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_inst", 64'(i), 64'(e.inst));
                        chk("sb_pc", obs_pc[i], e.pc);
                        chk("sb_illegal", obs_ill[i], e.ill);
                        chk("sb_wb_en", obs_wen[i], e.wen);
                        if (e.wen) begin
                            chk("sb_wb_addr", obs_wa[i], e.waddr);
                            chk("sb_wb_data", obs_wd[i], e.wdata);
                        end
                    end
                end else if (obs_ill[i] || obs_wen[i]) begin
                    chk("strobe_without_retire", {obs_ill[i], obs_wen[i]}, 0);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", obs_busy[i], 0);
            chk("rst_req", obs_req[i], 0);
            chk("rst_retire", obs_ret[i], 0);
            chk("rst_strobes", {obs_ill[i], obs_wen[i]}, 0);
        end
        chk("rst_pc0", pc0, 0);
        chk("rst_pc1", pc1, 12);
        reset_model();
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int i, input int n, input int budget, input bit gap);
        int k = 0;
        int last = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (obs_ret[i]) begin
                k++;
                if (gap && last >= 0) chk("retire_gap", 64'(c - last), 4);
                last = c;
                if (k == n) begin
                    start[i] = 1'b0;
                    return;
                end
            end
        end
        chk("run_timeout", 64'(k), 64'(n));
        start[i] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        ack[0] = 1'b0;   ack[1] = 1'b0;
        idata[0] = '0;   idata[1] = '0;
        stall[0] = 0;    stall[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) mem[i][a] = 32'h0;
        reset_model();
        repeat (2) @(negedge clk);
        do_reset();

        // Short program, ack on first fetch cycle.
        mem[0][0] = i_w(5'd1, 5'd0, 16'd5);
        mem[0][1] = i_w(5'd2, 5'd0, 16'hFFFD);
        mem[0][2] = r_w(6'b100000, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        start[0] = 1'b1;
        run_until(0, 3, 100, 1'b1);
        @(negedge clk);
        chk("prog_final_pc", pc0, 12);
        chk("prog_idle", busy0, 0);

        // Fetch stalled for seven cycles.
        @(negedge clk);
        do_reset();
        mem[0][0] = i_w(5'd1, 5'd0, 16'd7);
        stall[0] = 7;
        start[0] = 1'b1;
        repeat (7) begin
            @(negedge clk);
            chk("stall_addr", addr0, 0);
            chk("stall_busy", busy0, 1);
            chk("stall_req", req0, 1);
            chk("stall_noretire", ret0, 0);
        end
        repeat (3) begin
            @(negedge clk);
            chk("post_ack_noretire", ret0, 0);
        end
        @(negedge clk);
        chk("retire_3_after_ack", ret0, 1);
        start[0] = 1'b0;

        // Directed corner cases followed by a random stream.
        @(negedge clk);
        do_reset();
        mem[0][0] = i_w(5'd1, 5'd0, 16'h4000);
        mem[0][1] = r_w(6'b100000, 5'd1, 5'd1, 5'd1);
        mem[0][2] = r_w(6'b100000, 5'd1, 5'd1, 5'd1);
        mem[0][3] = i_w(5'd2, 5'd1, 16'd1);
        mem[0][4] = r_w(6'b100010, 5'd4, 5'd1, 5'd1);
        mem[0][5] = i_w(5'd0, 5'd0, 16'd9);
        mem[0][6] = 32'hFC00_0000;
        mem[0][7] = r_w(6'b011000, 5'd5, 5'd1, 5'd2);
        mem[0][8] = r_w(6'b100000, 5'd6, 5'd5, 5'd0);
        for (int a = 9; a < 48; a++) mem[0][a] = rnd_instr();
        start[0] = 1'b1;
        run_until(0, 48, 2000, 1'b1);
        @(negedge clk);
        chk("rand_final_pc", pc0, mpc[0]);

        // Drop start during EXEC, then reset during DECODE.
        @(negedge clk);
        do_reset();
        mem[0][0] = i_w(5'd1, 5'd0, 16'd33);
        mem[0][1] = i_w(5'd2, 5'd0, 16'd44);
        start[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("exec_busy", busy0, 1);
        start[0] = 1'b0;
        @(negedge clk);
        chk("drop_start_retire", ret0, 1);
        @(negedge clk);
        chk("drop_start_idle", busy0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_fetch", req0, 0);
        end
        chk("drop_start_pc", pc0, 4);
        start[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("decode_busy", busy0, 1);
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_retire", ret0, 0);
        end
        chk("abort_pc", pc0, 0);
        start[0] = 1'b1;
        run_until(0, 1, 50, 1'b0);

        // 16-bit datapath with a 4-bit wrapping PC.
        @(negedge clk);
        do_reset();
        mem[1][3] = i_w(5'd1, 5'd0, 16'h7FFF);
        mem[1][0] = i_w(5'd1, 5'd1, 16'h0001);
        start[1] = 1'b1;
        run_until(1, 2, 50, 1'b1);
        @(negedge clk);
        chk("wrap_pc", pc1, 4);
        chk("wrap_reg", mregs[1][1], 64'h8000);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter XLEN, default 32: datapath and register width; legal 8..32.
REQ-002 Parameter NREG, default 32: register count; power of two, 2..32.
REQ-003 Parameter PC_W, default 32: program counter width; legal 4..32.
REQ-004 Parameter RESET_PC, default 0: PC value loaded at reset; multiple of 4.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-low.
REQ-007 start_i  input  1  run enable; level-sensitive.
REQ-008 imem_req_o  output  1  instruction fetch request.
REQ-009 imem_addr_o  output  PC_W  fetch byte address, equal to current PC.
REQ-010 imem_ack_i  input  1  fetch acknowledge; imem_data_i valid in the same cycle.
REQ-011 imem_data_i  input  32  instruction word.
REQ-012 pc_o  output  PC_W  current PC.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 retire_o  output  1  one-cycle pulse per completed instruction, legal or illegal.
REQ-015 wb_en_o / wb_addr_o / wb_data_o  output  1 / 5 / XLEN  register write trace, valid while wb_en_o is high.
REQ-016 illegal_o  output  1  one-cycle pulse, coincident with retire_o, for an undecoded instruction.

Function
REQ-017 FSM states: IDLE, FETCH, DECODE, EXEC, WB.
REQ-018 IDLE -> FETCH when start_i=1; otherwise remain in IDLE.
REQ-019 FETCH: imem_req_o=1 and imem_addr_o stable; on imem_ack_i=1, latch imem_data_i into IR and go to DECODE; wait indefinitely without ack.
REQ-020 DECODE: read rs=IR[25:21] and rt=IR[20:16]; sign-extend IR[15:0] to XLEN; latch operands. Next state: EXEC.
REQ-021 EXEC: compute result into an XLEN register. Next state: WB.
REQ-022 WB: write result if legal; pulse retire_o; PC <= PC+4, wrapping modulo 2^PC_W; go to FETCH if start_i=1, else IDLE.
REQ-023 Minimum cost is 4 cycles per instruction when imem_ack_i is returned in the first FETCH cycle.
REQ-024 Opcode 000000 selects funct: 100000 add, 100010 sub, 100100 and, 100101 or; destination is rd=IR[15:11].
REQ-025 Opcode 001000 selects addi: rs + sext(imm); destination is rt.
REQ-026 All arithmetic is modulo 2^XLEN, with no overflow trap.
REQ-027 Any other opcode/funct is illegal: no register write, illegal_o=1 in WB, PC still advances.
REQ-028 Register 0 reads as zero; writes to it are discarded, and wb_en_o is low for such writes.
REQ-029 Register index uses the low log2(NREG) bits of the 5-bit field; wb_addr_o reports the full 5-bit field.
REQ-030 A register write in WB is visible to the DECODE read of the next instruction.
REQ-031 Dropping start_i mid-instruction completes that instruction, then enters IDLE after WB.

Reset
REQ-032 With rst_i=0 at an edge: state=IDLE, PC=RESET_PC, IR=0, all registers=0.
REQ-033 During reset, imem_req_o, retire_o, illegal_o, wb_en_o and busy_o are all 0.
REQ-034 Reset asserted in any state aborts the in-flight instruction, with no write and no retire.

Configuration
REQ-035 Macro MC_CPU_MUL_EN, when defined: funct 011000 = mul, writing the low XLEN bits of rs*rt to rd.
REQ-036 Macro MC_CPU_MUL_EN, when undefined: funct 011000 is illegal per REQ-027, and no multiplier is synthesised.

Structure
REQ-037 Package mc_cpu_pkg: opcode and funct constants, ALU-op enum, FSM state enum.
REQ-038 Sub-module mc_regfile: parametrised by XLEN and NREG; two async read ports; one sync write port with the zero-register rule.

Verification
REQ-039 Reset then start_i=1, ack every FETCH cycle, program {addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2} -> wb_data_o = 5, 0xFFFFFFFD, 2; retire_o every 4 cycles; pc_o ends at 12.
REQ-040 Hold imem_ack_i low for 7 cycles on the first fetch -> imem_addr_o stays 0, busy_o=1, no retire until ack; instruction then retires 3 cycles after ack.
REQ-041 Issue sub $4,$1,$1, then addi $0,$0,9, then an instruction with opcode 111111 -> $4=0; the addi gives wb_en_o=0; the 111111 instruction gives illegal_o=1; pc_o advances for all three.
REQ-042 Set XLEN=16, PC_W=4, RESET_PC=12 and run 2 instructions -> PC wraps to 0 then 4; addi $1,$0,0x7FFF then addi $1,$1,1 -> 0x8000.
REQ-043 With MC_CPU_MUL_EN defined: mul $5,$1,$2 with $1=0x10000 and $2=0x10001 -> 0x00010000; without the macro the same word -> illegal_o=1 and $5 unchanged.
REQ-044 Drop start_i during EXEC -> the instruction retires and the FSM enters IDLE; assert rst_i=0 during DECODE -> no retire, and PC returns to RESET_PC.
